pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
Hazard and sequencing controller for the 5-stage pipeline; sits beside the ID-stage control decoder.
- Keeps its own shadow copy of the EX/MEM destination info (wreg, m2reg, dst) and produces the ID-stage forwarding selects.
- Produces load-use interlocks and branch flush when delay slots are disabled.
- Sequences a multi-cycle divide by freezing the front of the pipeline while EX is busy.

Parameters:
DIV_CYCLES, 32, cycles the divide occupies EX (legal range 1..255)
DELAY_SLOT, 1, 1 = branch delay slot (no flush); 0 = flush IF/ID on taken branch/jump

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_wreg  in  1  ID instruction writes the register file
id_m2reg  in  1  ID instruction is a load
id_dst  in  5  final destination register (after regrt/jal mux)
id_div  in  1  ID instruction is a multi-cycle divide
id_branch_taken  in  1  branch/jump resolved taken in ID (pcsource != 0)
fwd_a  out  2  rs operand select: 00 regfile, 01 EX ALU, 10 MEM ALU, 11 MEM load data
fwd_b  out  2  rt operand select, same encoding
stall_pc  out  1  hold PC
stall_ifid  out  1  hold IF/ID register
bubble_idex  out  1  load NOP (wreg=0, wmem=0) into ID/EX
stall_idex  out  1  hold ID/EX register (divide running)
bubble_exmem  out  1  load NOP into EX/MEM
flush_ifid  out  1  replace IF/ID with NOP
div_start  out  1  one-cycle pulse: divider begins operation
div_busy  out  1  divide occupying EX

Behaviour:
Reset:
- All outputs are 0; fsm = IDLE; counter = 0; shadow ex_wreg/mem_wreg = 0.

Shadow registers update every edge, mirroring the datapath:
- ex_* <= id_* unless stall_idex (hold) or bubble_idex (ex_wreg <= 0).
- mem_* <= ex_* unless bubble_exmem (mem_wreg <= 0).

Forwarding (combinational, per operand, operand register r):
- EX match (ex_wreg, ex_dst==r, r!=0, !ex_m2reg) -> 01.
- Else MEM match (mem_wreg, mem_dst==r, r!=0) -> 10, or 11 if mem_m2reg.
- Else 00.
- EX has priority over MEM. Register 0 is never forwarded.

Load-use (combinational):
- Condition: ex_wreg & ex_m2reg & ex_dst!=0 & ((id_use_rs & ex_dst==id_rs) | (id_use_rt & ex_dst==id_rt)).
- Response: stall_pc = stall_ifid = bubble_idex = 1. Lasts exactly 1 cycle, because the load moves to MEM and is then forwarded via 11.

FSM IDLE / DIV_RUN:
- IDLE: if id_div & !loaduse & DIV_CYCLES>1, the divide issues to EX at the edge; next state DIV_RUN, counter <= DIV_CYCLES-1.
- DIV_CYCLES==1: the FSM stays IDLE; div_start pulses the cycle after issue.
- DIV_RUN, first cycle: div_start=1.
- DIV_RUN: div_busy=1. While counter!=0: stall_pc = stall_ifid = stall_idex = bubble_exmem = 1, and counter decrements.
- DIV_RUN, counter==0: stalls deasserted, divide result advances to MEM, next state IDLE.
- Total EX occupancy = DIV_CYCLES cycles.

Priority and simultaneous events:
- Load-use beats divide issue: the divide waits one cycle.
- During load-use or DIV_RUN stalls, id_branch_taken is ignored (flush_ifid=0); the branch is re-evaluated after the stall.
- Flush: DELAY_SLOT==0 & id_branch_taken & no stall -> flush_ifid=1 for that cycle.
- Back-to-back divides: the second issues in the cycle DIV_RUN exits (counter==0), if no load-use.

Reset mid-divide:
- Immediate return to IDLE, all stall outputs drop asynchronously, shadow wreg bits cleared.

Decomposition:
- Shared package: fwd select encodings (FWD_RF/EXALU/MEMALU/MEMDATA) and fsm state encoding, reused by the datapath operand muxes.
- One sub-module, hazard_fwd_unit: the combinational forwarding/load-use compare, instanced as the single compare block.
- FSM, counter and shadow registers stay in the top.

Test Plan:
- Reset: assert rst at any time -> all outputs 0 asynchronously. Release, then add r1 -> add with rs=r1 -> fwd_a=01. One instruction later, reading r1 -> fwd_a=10. Reading r0 with r0 "written" -> fwd 00.
- lw r2 then add reading r2 as rt -> one cycle with stall_pc=stall_ifid=bubble_idex=1. Next cycle fwd_b=11, no stall.
- Priority: EX and MEM both targeting r3 -> fwd_a=01 (EX wins).
- div with DIV_CYCLES=4 -> div_start for one cycle, div_busy for 4 cycles. stall_idex/bubble_exmem held for 3 cycles. A following consumer of the div destination gets fwd=01 on release.
- Simultaneous load-use and id_div -> divide delayed exactly one cycle. Branch taken during DIV_RUN with DELAY_SLOT=0 -> no flush until release, then flush_ifid=1 for one cycle.
- Assert rst on the 2nd DIV_RUN cycle -> stalls drop immediately; after release the FSM is IDLE and a new div restarts the full count.

Source files
------------

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller and the datapath
// operand muxes. Holds the forwarding-select encodings, the divide sequencer
// states, and the per-stage destination record.
package pipe_hazard_ctrl_pkg;

    localparam int REG_W = 5;
    localparam int CNT_W = 8;

    // Operand source select, shared with the ID-stage operand muxes.
    typedef enum logic [1:0] {
        FWD_RF      = 2'b00,
        FWD_EXALU   = 2'b01,
        FWD_MEMALU  = 2'b10,
        FWD_MEMDATA = 2'b11
    } fwd_sel_t;

    typedef enum logic {
        IDLE    = 1'b0,
        DIV_RUN = 1'b1
    } div_state_t;

    // Destination info tracked for an instruction sitting in EX or MEM.
    typedef struct packed {
        logic             wreg;
        logic             m2reg;
        logic [REG_W-1:0] dst;
    } dst_info_t;

    // Source select for one operand register. A younger producer in EX wins
    // over MEM. A load still in EX has no data yet, so it is never an EX
    // source. Register 0 is hard-wired and never forwarded.
    function automatic fwd_sel_t fwd_select(input logic [REG_W-1:0] r,
                                            input dst_info_t        ex,
                                            input dst_info_t        mem);
        if (ex.wreg && !ex.m2reg && (ex.dst == r) && (r != '0))
            return FWD_EXALU;
        if (mem.wreg && (mem.dst == r) && (r != '0))
            return mem.m2reg ? FWD_MEMDATA : FWD_MEMALU;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit.sv
// Combinational compare block: ID source registers against the EX/MEM
// destination shadows. Produces both operand selects and the load-use hit.
module hazard_fwd_unit
    import pipe_hazard_ctrl_pkg::*;
(
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  dst_info_t        ex,
    input  dst_info_t        mem,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b,
    output logic             loaduse
);

    assign fwd_a = fwd_select(id_rs, ex, mem);
    assign fwd_b = fwd_select(id_rt, ex, mem);

    // A load in EX whose destination is read by ID cannot be forwarded yet.
    always_comb begin
        loaduse = ex.wreg && ex.m2reg && (ex.dst != '0) &&
                  ((id_use_rs && (ex.dst == id_rs)) ||
                   (id_use_rt && (ex.dst == id_rt)));
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage pipeline. Shadows the
// EX/MEM destination info, drives the forwarding selects, load-use
// interlocks, taken-branch flush, and the multi-cycle divide freeze.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int unsigned DIV_CYCLES = 32,
    parameter bit          DELAY_SLOT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_wreg,
    input  logic             id_m2reg,
    input  logic [REG_W-1:0] id_dst,
    input  logic             id_div,
    input  logic             id_branch_taken,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic             stall_pc,
    output logic             stall_ifid,
    output logic             bubble_idex,
    output logic             stall_idex,
    output logic             bubble_exmem,
    output logic             flush_ifid,
    output logic             div_start,
    output logic             div_busy
);

    // Counter reload: the first EX cycle is the issue cycle itself.
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam bit               MULTI    = (DIV_CYCLES > 1);

    div_state_t       state, state_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic             start_q, start_nxt;
    logic             loaduse;
    logic             div_stall;
    logic             issue;
    dst_info_t        ex_q, mem_q, id_info;
    fwd_sel_t         fwd_a_sel, fwd_b_sel;

    assign id_info = '{wreg: id_wreg, m2reg: id_m2reg, dst: id_dst};

    hazard_fwd_unit u_fwd (
        .id_rs     (id_rs),
        .id_rt     (id_rt),
        .id_use_rs (id_use_rs),
        .id_use_rt (id_use_rt),
        .ex        (ex_q),
        .mem       (mem_q),
        .fwd_a     (fwd_a_sel),
        .fwd_b     (fwd_b_sel),
        .loaduse   (loaduse)
    );

    assign fwd_a = fwd_a_sel;
    assign fwd_b = fwd_b_sel;

    // Divide sequencer: next state, counter and all stall/flush outputs.
    always_comb begin
        // NOTE: every signal gets a default first so no path infers a latch.
        state_nxt = state;
        cnt_nxt   = cnt;
        start_nxt = 1'b0;
        div_stall = 1'b0;
        issue     = id_div && !loaduse;

        unique case (state)
            IDLE: begin
                if (issue) begin
                    start_nxt = 1'b1;
                    if (MULTI) begin
                        state_nxt = DIV_RUN;
                        cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            DIV_RUN: begin
                if (cnt != '0) begin
                    div_stall = 1'b1;
                    cnt_nxt   = cnt - CNT_W'(1);
                end else if (issue) begin
                    // Back-to-back divide takes EX as the previous one leaves.
                    start_nxt = 1'b1;
                    cnt_nxt   = CNT_LOAD;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        stall_pc     = loaduse || div_stall;
        stall_ifid   = loaduse || div_stall;
        bubble_idex  = loaduse;
        stall_idex   = div_stall;
        bubble_exmem = div_stall;
        // Branch is ignored while stalled; it is re-evaluated on release.
        // Gated by rst so every output is quiet while reset is held.
        flush_ifid   = !rst && !DELAY_SLOT && id_branch_taken &&
                       !loaduse && !div_stall;
        div_start    = start_q;
        div_busy     = (state == DIV_RUN) || start_q;
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            start_q <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments only.
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            start_q <= start_nxt;
        end
    end

    // EX/MEM destination shadows, following the datapath register enables.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_q  <= '0;
            mem_q <= '0;
        end else begin
            if (!stall_idex)
                ex_q <= bubble_idex ? '0 : id_info;
            mem_q <= bubble_exmem ? '0 : ex_q;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl with DIV_CYCLES=4, DELAY_SLOT=0.
// ctrl packs {stall_pc, stall_ifid, bubble_idex, stall_idex, bubble_exmem,
// flush_ifid, div_start, div_busy}.
module tb_pipe_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, id_dst;
    logic       id_use_rs, id_use_rt, id_wreg, id_m2reg, id_div, id_branch_taken;
    logic [1:0] fwd_a, fwd_b;
    logic       stall_pc, stall_ifid, bubble_idex, stall_idex, bubble_exmem;
    logic       flush_ifid, div_start, div_busy;
    logic [7:0] ctrl;

    int n_total = 0;
    int n_pass  = 0;

    pipe_hazard_ctrl #(.DIV_CYCLES(4), .DELAY_SLOT(1'b0)) dut (
        .clk             (clk),
        .rst             (rst),
        .id_rs           (id_rs),
        .id_rt           (id_rt),
        .id_use_rs       (id_use_rs),
        .id_use_rt       (id_use_rt),
        .id_wreg         (id_wreg),
        .id_m2reg        (id_m2reg),
        .id_dst          (id_dst),
        .id_div          (id_div),
        .id_branch_taken (id_branch_taken),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .stall_pc        (stall_pc),
        .stall_ifid      (stall_ifid),
        .bubble_idex     (bubble_idex),
        .stall_idex      (stall_idex),
        .bubble_exmem    (bubble_exmem),
        .flush_ifid      (flush_ifid),
        .div_start       (div_start),
        .div_busy        (div_busy)
    );

    always #5 clk = ~clk;

    assign ctrl = {stall_pc, stall_ifid, bubble_idex, stall_idex,
                   bubble_exmem, flush_ifid, div_start, div_busy};

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp)
            $display("FAIL %s: got %b, expected %b", tag, got, exp);
        else
            n_pass++;
    endtask

    // Present the ID-stage instruction, then let the combinational outputs settle.
    task automatic set_id(input logic [4:0] rs, input logic [4:0] rt,
                          input logic urs, input logic urt,
                          input logic wreg, input logic m2, input logic [4:0] dst,
                          input logic div, input logic br);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_wreg = wreg; id_m2reg = m2; id_dst = dst;
        id_div = div; id_branch_taken = br;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        id_rs = '0; id_rt = '0; id_dst = '0;
        id_use_rs = 1'b0; id_use_rt = 1'b0; id_wreg = 1'b0; id_m2reg = 1'b0;
        id_div = 1'b0; id_branch_taken = 1'b1;
        #2;
        check("rst_ctrl", ctrl, 8'h00);
        check("rst_fwd",  {fwd_a, fwd_b}, 8'h00);
        @(posedge clk);
        @(posedge clk);
        #3 rst = 1'b0;

        // Forwarding from EX, then MEM, register 0 never forwarded
        set_id(5, 6, 1, 1, 1, 0, 1, 0, 0);
        check("A_fwd_a", fwd_a, 0);
        check("A_ctrl", ctrl, 8'h00);
        tick();
        set_id(1, 7, 1, 1, 1, 0, 8, 0, 0);
        check("B_fwd_a_ex", fwd_a, 1);
        check("B_fwd_b", fwd_b, 0);
        tick();
        set_id(1, 0, 1, 1, 1, 0, 0, 0, 0);
        check("C_fwd_a_mem", fwd_a, 2);
        check("C_fwd_b_r0", fwd_b, 0);
        tick();
        set_id(0, 8, 1, 1, 0, 0, 0, 0, 0);
        check("D_fwd_a_r0_ex", fwd_a, 0);
        check("D_fwd_b_mem", fwd_b, 2);
        tick();

        // Load-use: one stall cycle, then MEM load data; branch held off by stall
        set_id(0, 0, 1, 0, 1, 1, 2, 0, 0);
        check("E_fwd_a_r0_mem", fwd_a, 0);
        check("E_ctrl", ctrl, 8'h00);
        tick();
        set_id(3, 2, 1, 1, 1, 0, 4, 0, 1);
        check("F_loaduse_ctrl", ctrl, 8'b1110_0000);
        check("F_fwd_b", fwd_b, 0);
        tick();
        check("G_fwd_b_memdata", fwd_b, 3);
        check("G_ctrl_flush", ctrl, 8'b0000_0100);
        tick();

        // EX beats MEM for the same register
        set_id(0, 0, 0, 0, 1, 0, 3, 0, 0);
        tick();
        set_id(10, 11, 1, 1, 1, 0, 3, 0, 0);
        check("I_fwd_a", fwd_a, 0);
        tick();
        set_id(3, 4, 1, 1, 0, 0, 0, 0, 0);
        check("J_fwd_a_prio", fwd_a, 1);
        check("J_fwd_b", fwd_b, 0);
        tick();

        // Load-use coinciding with divide issue: divide waits one cycle
        set_id(0, 0, 0, 0, 1, 1, 5, 0, 0);
        check("K_ctrl", ctrl, 8'h00);
        tick();
        set_id(5, 0, 1, 0, 1, 0, 6, 1, 0);
        check("L_loaduse_div", ctrl, 8'b1110_0000);
        tick();
        check("M_fwd_a_memdata", fwd_a, 3);
        check("M_ctrl_issue", ctrl, 8'h00);
        tick();
        // Divide running; consumer of r6 waits with a taken branch
        set_id(6, 0, 1, 0, 1, 0, 7, 0, 1);
        check("N1_ctrl", ctrl, 8'b1101_1011);
        check("N1_fwd_a", fwd_a, 1);
        tick();
        check("N2_ctrl", ctrl, 8'b1101_1001);
        tick();
        check("N3_ctrl", ctrl, 8'b1101_1001);
        tick();
        check("N4_ctrl_release", ctrl, 8'b0000_0101);
        check("N4_fwd_a", fwd_a, 1);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("N5_ctrl", ctrl, 8'h00);
        tick();

        // Reset in the 2nd divide cycle drops everything asynchronously
        set_id(0, 0, 0, 0, 1, 0, 9, 1, 0);
        check("P_ctrl", ctrl, 8'h00);
        tick();
        set_id(9, 0, 1, 0, 0, 0, 0, 0, 0);
        check("Q1_ctrl", ctrl, 8'b1101_1011);
        tick();
        check("Q2_ctrl", ctrl, 8'b1101_1001);
        check("Q2_fwd_a", fwd_a, 1);
        #2 rst = 1'b1;
        #1;
        check("Q2_rst_ctrl", ctrl, 8'h00);
        check("Q2_rst_fwd_a", fwd_a, 0);
        @(posedge clk);
        #3 rst = 1'b0;

        // Fresh divide runs the full count, then a back-to-back divide
        set_id(0, 0, 0, 0, 1, 0, 10, 1, 0);
        check("R0_ctrl", ctrl, 8'h00);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("R1_ctrl", ctrl, 8'b1101_1011);
        tick();
        for (int i = 2; i <= 3; i++) begin
            check($sformatf("R%0d_ctrl", i), ctrl, 8'b1101_1001);
            tick();
        end
        set_id(0, 0, 0, 0, 1, 0, 11, 1, 0);
        check("R4_ctrl_b2b", ctrl, 8'b0000_0001);
        tick();
        set_id(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("S1_ctrl", ctrl, 8'b1101_1011);
        tick();
        for (int i = 2; i <= 3; i++) begin
            check($sformatf("S%0d_ctrl", i), ctrl, 8'b1101_1001);
            tick();
        end
        check("S4_ctrl", ctrl, 8'b0000_0001);
        tick();
        check("S5_ctrl_idle", ctrl, 8'h00);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
